// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: walks a descriptor table one layer at a time,
// starts the accelerator, brokers weight fetches per batch and reports completion.
// Optional watchdog on WAIT/WFETCH is compiled in with `define FC_SEQ_TIMEOUT_EN.
module fc_layer_sequencer #(
  parameter int unsigned N_LAYERS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned SRAM_ADDR_W    = 16,
  localparam int unsigned IDX_W         = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_async_n_i,
  // descriptor programming
  input  logic                   cfg_wr_en_i,
  input  logic [IDX_W-1:0]       cfg_wr_idx_i,
  input  logic                   cfg_load_from_sram_i,
  input  logic [SRAM_ADDR_W-1:0] cfg_sram_addr_i,
  input  logic [15:0]            cfg_load_len_i,
  input  logic [15:0]            cfg_calc_len_i,
  input  logic [9:0]             cfg_rd_base_i,
  input  logic [9:0]             cfg_wr_base_i,
  input  logic [2:0]             cfg_flags_i,
  input  logic [4:0]             cfg_shift_i,
  // control / status
  input  logic [2:0]             num_layers_i,
  input  logic                   run_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [IDX_W-1:0]       layer_idx_o,
  output logic [7:0]             batch_idx_o,
  // accelerator side
  output logic                   acc_start_o,
  output logic                   acc_calc_start_o,
  output logic                   acc_weight_ack_o,
  output logic                   acc_load_from_sram_o,
  output logic [SRAM_ADDR_W-1:0] acc_load_sram_addr_o,
  output logic [31:0]            acc_load_len_o,
  output logic [31:0]            acc_calc_len_o,
  output logic                   acc_do_bias_o,
  output logic                   acc_do_relu_o,
  output logic                   acc_do_quant_o,
  output logic [4:0]             acc_quant_shift_o,
  output logic [9:0]             acc_fb_rd_base_o,
  output logic [9:0]             acc_fb_wr_base_o,
  input  logic                   acc_weight_req_i,
  input  logic                   acc_done_i,
  // weight fetch side
  output logic                   wfetch_req_o,
  output logic [IDX_W-1:0]       wfetch_layer_o,
  output logic [7:0]             wfetch_batch_o,
  input  logic                   wfetch_ack_i
);

  // num_layers_i is 3 bits wide, so a deeper table could never be fully used
  if (N_LAYERS < 1 || N_LAYERS > 7 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fc_layer_sequencer: unsupported N_LAYERS/TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StWfetch, StGrant, StNext, StFinish
  } state_e;

  typedef struct packed {
    logic                   load_from_sram;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [15:0]            load_len;
    logic [15:0]            calc_len;
    logic [9:0]             rd_base;
    logic [9:0]             wr_base;
    logic [2:0]             flags;     // {quant, relu, bias}
    logic [4:0]             shift;
  } desc_t;

  desc_t            table_q [N_LAYERS];
  desc_t            wr_desc;
  logic             table_we;

  state_e           state_q, state_d;
  logic [2:0]       num_layers_q, num_layers_d;
  logic [IDX_W-1:0] layer_idx_q, layer_idx_d;
  logic [7:0]       batch_idx_q, batch_idx_d;
  desc_t            acc_cfg_q, acc_cfg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             acc_start_q, acc_start_d;
  logic             grant_q, grant_d;
  logic             wfetch_req_q, wfetch_req_d;
  logic             run_ok;
  logic             last_layer;

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign wr_desc = '{
    load_from_sram: cfg_load_from_sram_i,
    sram_addr:      cfg_sram_addr_i,
    load_len:       cfg_load_len_i,
    calc_len:       cfg_calc_len_i,
    rd_base:        cfg_rd_base_i,
    wr_base:        cfg_wr_base_i,
    flags:          cfg_flags_i,
    shift:          cfg_shift_i
  };

  // Table is only writable while idle so a running layer never sees its descriptor move
  assign table_we = cfg_wr_en_i && (state_q == StIdle) && (32'(cfg_wr_idx_i) < N_LAYERS);

  assign run_ok     = (num_layers_i != 3'd0) && (32'(num_layers_i) <= N_LAYERS);
  assign last_layer = (32'(layer_idx_q) == (32'(num_layers_q) - 32'd1));

  // Descriptor table storage, cleared by reset
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      for (int i = 0; i < int'(N_LAYERS); i++) begin
        table_q[i] <= '0;
      end
    end else if (table_we) begin
      table_q[cfg_wr_idx_i] <= wr_desc;
    end
  end

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d      = state_q;
    num_layers_d = num_layers_q;
    layer_idx_d  = layer_idx_q;
    batch_idx_d  = batch_idx_q;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          if (run_ok) begin
            num_layers_d = num_layers_i;
            layer_idx_d  = '0;
            batch_idx_d  = '0;
            state_d      = StIssue;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // layer completion wins over a simultaneous weight request
        if (acc_done_i) begin
          state_d = last_layer ? StFinish : StNext;
        end else if (acc_weight_req_i) begin
          state_d = StWfetch;
        end
      end
      StWfetch: begin
        if (wfetch_ack_i) begin
          state_d = StGrant;
        end
      end
      StGrant: begin
        batch_idx_d = batch_idx_q + 8'd1;
        state_d     = StWait;
      end
      StNext: begin
        layer_idx_d = layer_idx_q + IDX_W'(1);
        batch_idx_d = '0;
        state_d     = StIssue;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

`ifdef FC_SEQ_TIMEOUT_EN
    // Watchdog only fires when the state had no other event this cycle
    if ((state_q == StWait || state_q == StWfetch) && (state_d == state_q) &&
        (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
`endif

    // Abort overrides everything, including a watchdog error
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      err_d   = 1'b0;
    end

`ifdef FC_SEQ_TIMEOUT_EN
    tmo_d = ((state_d == state_q) && (state_q == StWait || state_q == StWfetch)) ?
            tmo_q + TMO_W'(1) : '0;
`endif

    // Outputs are registered from the state being entered
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StFinish);
    acc_start_d  = (state_d == StIssue);
    grant_d      = (state_d == StGrant);
    wfetch_req_d = (state_d == StWfetch);
    // Capture the descriptor on entry to ISSUE and hold it through the layer
    acc_cfg_d    = ((state_d == StIssue) && (state_q != StIssue)) ? table_q[layer_idx_d]
                                                                  : acc_cfg_q;
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state_q      <= StIdle;
      num_layers_q <= '0;
      layer_idx_q  <= '0;
      batch_idx_q  <= '0;
      acc_cfg_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      acc_start_q  <= 1'b0;
      grant_q      <= 1'b0;
      wfetch_req_q <= 1'b0;
`ifdef FC_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      num_layers_q <= num_layers_d;
      layer_idx_q  <= layer_idx_d;
      batch_idx_q  <= batch_idx_d;
      acc_cfg_q    <= acc_cfg_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      acc_start_q  <= acc_start_d;
      grant_q      <= grant_d;
      wfetch_req_q <= wfetch_req_d;
`ifdef FC_SEQ_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign err_o                = err_q;
  assign layer_idx_o          = layer_idx_q;
  assign batch_idx_o          = batch_idx_q;

  assign acc_start_o          = acc_start_q;
  assign acc_calc_start_o     = grant_q;
  assign acc_weight_ack_o     = grant_q;
  assign acc_load_from_sram_o = acc_cfg_q.load_from_sram;
  assign acc_load_sram_addr_o = acc_cfg_q.sram_addr;
  assign acc_load_len_o       = {16'd0, acc_cfg_q.load_len};
  assign acc_calc_len_o       = {16'd0, acc_cfg_q.calc_len};
  assign acc_do_bias_o        = acc_cfg_q.flags[0];
  assign acc_do_relu_o        = acc_cfg_q.flags[1];
  assign acc_do_quant_o       = acc_cfg_q.flags[2];
  assign acc_quant_shift_o    = acc_cfg_q.shift;
  assign acc_fb_rd_base_o     = acc_cfg_q.rd_base;
  assign acc_fb_wr_base_o     = acc_cfg_q.wr_base;

  assign wfetch_req_o         = wfetch_req_q;
  assign wfetch_layer_o       = layer_idx_q;
  assign wfetch_batch_o       = batch_idx_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed self-checking bench for fc_layer_sequencer.
module tb_fc_layer_sequencer;

  localparam int unsigned NL   = 4;
  localparam int unsigned AW   = 16;
  localparam int unsigned TMO  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_wr_en, cfg_load_from_sram;
  logic [1:0]    cfg_wr_idx;
  logic [AW-1:0] cfg_sram_addr;
  logic [15:0]   cfg_load_len, cfg_calc_len;
  logic [9:0]    cfg_rd_base, cfg_wr_base;
  logic [2:0]    cfg_flags;
  logic [4:0]    cfg_shift;
  logic [2:0]    num_layers;
  logic          run, abort_s;
  logic          busy, done, err;
  logic [1:0]    layer_idx;
  logic [7:0]    batch_idx;
  logic          acc_start, acc_calc_start, acc_weight_ack, acc_load_from_sram;
  logic [AW-1:0] acc_load_sram_addr;
  logic [31:0]   acc_load_len, acc_calc_len;
  logic          acc_do_bias, acc_do_relu, acc_do_quant;
  logic [4:0]    acc_quant_shift;
  logic [9:0]    acc_fb_rd_base, acc_fb_wr_base;
  logic          acc_weight_req, acc_done;
  logic          wfetch_req;
  logic [1:0]    wfetch_layer;
  logic [7:0]    wfetch_batch;
  logic          wfetch_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int grants0  = 0;
  int grants1  = 0;
  bit ok;
  int cnt;

  fc_layer_sequencer #(
    .N_LAYERS      (NL),
    .TIMEOUT_CYCLES(TMO),
    .SRAM_ADDR_W   (AW)
  ) dut (
    .clk_i               (clk),
    .rst_async_n_i       (rst_n),
    .cfg_wr_en_i         (cfg_wr_en),
    .cfg_wr_idx_i        (cfg_wr_idx),
    .cfg_load_from_sram_i(cfg_load_from_sram),
    .cfg_sram_addr_i     (cfg_sram_addr),
    .cfg_load_len_i      (cfg_load_len),
    .cfg_calc_len_i      (cfg_calc_len),
    .cfg_rd_base_i       (cfg_rd_base),
    .cfg_wr_base_i       (cfg_wr_base),
    .cfg_flags_i         (cfg_flags),
    .cfg_shift_i         (cfg_shift),
    .num_layers_i        (num_layers),
    .run_i               (run),
    .abort_i             (abort_s),
    .busy_o              (busy),
    .done_o              (done),
    .err_o               (err),
    .layer_idx_o         (layer_idx),
    .batch_idx_o         (batch_idx),
    .acc_start_o         (acc_start),
    .acc_calc_start_o    (acc_calc_start),
    .acc_weight_ack_o    (acc_weight_ack),
    .acc_load_from_sram_o(acc_load_from_sram),
    .acc_load_sram_addr_o(acc_load_sram_addr),
    .acc_load_len_o      (acc_load_len),
    .acc_calc_len_o      (acc_calc_len),
    .acc_do_bias_o       (acc_do_bias),
    .acc_do_relu_o       (acc_do_relu),
    .acc_do_quant_o      (acc_do_quant),
    .acc_quant_shift_o   (acc_quant_shift),
    .acc_fb_rd_base_o    (acc_fb_rd_base),
    .acc_fb_wr_base_o    (acc_fb_wr_base),
    .acc_weight_req_i    (acc_weight_req),
    .acc_done_i          (acc_done),
    .wfetch_req_o        (wfetch_req),
    .wfetch_layer_o      (wfetch_layer),
    .wfetch_batch_o      (wfetch_batch),
    .wfetch_ack_i        (wfetch_ack)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (acc_calc_start) begin
      if (layer_idx == 2'd0) grants0++;
      else grants1++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_desc(input logic [1:0] idx, input logic lfs, input logic [AW-1:0] addr,
                            input logic [15:0] ll, input logic [15:0] cl,
                            input logic [9:0] rb, input logic [9:0] wb,
                            input logic [2:0] fl, input logic [4:0] sh);
    cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_load_from_sram = lfs; cfg_sram_addr = addr;
    cfg_load_len = ll; cfg_calc_len = cl; cfg_rd_base = rb; cfg_wr_base = wb;
    cfg_flags = fl; cfg_shift = sh;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // Bounded wait for the fetch request to appear
  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wfetch_req) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // One weight fetch from WAIT: request, hold 3 cycles, ack, check grant
  task automatic do_fetch(input int lay, input int bat);
    bit seen;
    acc_weight_req = 1'b1;
    wait_req(seen);
    chk("fetch_seen", 32'(seen), 32'd1);
    chk("fetch_layer", 32'(wfetch_layer), 32'(lay));
    chk("fetch_batch", 32'(wfetch_batch), 32'(bat));
    acc_weight_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("fetch_hold", 32'(wfetch_req), 32'd1);
    end
    wfetch_ack = 1'b1;
    @(negedge clk);
    chk("grant_pair", 32'({acc_weight_ack, acc_calc_start}), 32'd3);
    chk("grant_req_drop", 32'(wfetch_req), 32'd0);
    wfetch_ack = 1'b0;
    @(negedge clk);
    chk("grant_1cyc", 32'(acc_calc_start), 32'd0);
    chk("batch_inc", 32'(batch_idx), 32'(bat + 1));
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_load_from_sram = 1'b0; cfg_sram_addr = '0;
    cfg_load_len = '0; cfg_calc_len = '0; cfg_rd_base = '0; cfg_wr_base = '0;
    cfg_flags = '0; cfg_shift = '0; num_layers = '0; run = 1'b0; abort_s = 1'b0;
    acc_weight_req = 1'b0; acc_done = 1'b0; wfetch_ack = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_start_req", 32'({acc_start, wfetch_req}), 32'd0);
    chk("rst_idx", 32'({layer_idx, batch_idx}), 32'd0);
    chk("rst_calc_len", acc_calc_len, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-layer run
    write_desc(2'd0, 1'b1, 16'h1234, 16'd300, 16'd150, 10'd5, 10'd7, 3'b101, 5'd3);
    write_desc(2'd1, 1'b0, 16'h0042, 16'd80, 16'd40, 10'd9, 10'd11, 3'b010, 5'd12);
    run = 1'b1; num_layers = 3'd2;
    @(negedge clk);
    run = 1'b0;
    chk("l0_start", 32'({acc_start, busy}), 32'd3);
    chk("l0_calc_len", acc_calc_len, 32'd150);
    chk("l0_load_len", acc_load_len, 32'd300);
    chk("l0_addr", 32'({acc_load_from_sram, acc_load_sram_addr}), 32'h11234);
    chk("l0_bases", 32'({acc_fb_rd_base, acc_fb_wr_base}), {12'd0, 10'd5, 10'd7});
    chk("l0_flags", 32'({acc_do_quant, acc_do_relu, acc_do_bias, acc_quant_shift}),
        32'({3'b101, 5'd3}));
    @(negedge clk);
    chk("start_1cyc", 32'(acc_start), 32'd0);
    do_fetch(0, 0);
    do_fetch(0, 1);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    chk("next_no_done", 32'({done, busy}), 32'd1);
    @(negedge clk);
    chk("l1_start", 32'(acc_start), 32'd1);
    chk("l1_idx", 32'({layer_idx, batch_idx}), 32'({2'd1, 8'd0}));
    chk("l1_calc_len", acc_calc_len, 32'd40);
    chk("l1_flags", 32'({acc_do_quant, acc_do_relu, acc_do_bias}), 32'b010);
    @(negedge clk);
    // Write attempt while in WAIT must be ignored
    write_desc(2'd0, 1'b0, 16'hFFFF, 16'd1, 16'd999, 10'd1, 10'd1, 3'b000, 5'd31);
    write_desc(2'd1, 1'b1, 16'hFFFF, 16'd2, 16'd777, 10'd2, 10'd2, 3'b111, 5'd30);
    chk("wait_wr_len", acc_calc_len, 32'd40);
    chk("wait_wr_shift", 32'(acc_quant_shift), 32'd12);
    do_fetch(1, 0);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    #1;
    chk("done_pulse", 32'({done, busy}), 32'd3);
    @(negedge clk);
    #1;
    chk("done_1cyc", 32'({done, busy}), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("grants_l0", 32'(grants0), 32'd2);
    chk("grants_l1", 32'(grants1), 32'd1);

    // Illegal layer counts
    run = 1'b1; num_layers = 3'd0;
    @(negedge clk);
    run = 1'b0;
    chk("err_zero", 32'({err, busy}), 32'd2);
    @(negedge clk);
    chk("err_zero_1cyc", 32'({err, busy}), 32'd0);
    run = 1'b1; num_layers = 3'd5;
    @(negedge clk);
    run = 1'b0;
    chk("err_five", 32'({err, busy}), 32'd2);
    @(negedge clk);
    #1;
    chk("err_five_1cyc", 32'({err, busy}), 32'd0);
    chk("err_count", 32'(err_cnt), 32'd2);

    // Abort in WFETCH; also confirms entry 0 survived the ignored write
    run = 1'b1; num_layers = 3'd1;
    @(negedge clk);
    run = 1'b0;
    chk("tbl_kept_len", acc_calc_len, 32'd150);
    chk("tbl_kept_flags", 32'({acc_do_quant, acc_do_bias, acc_quant_shift}),
        32'({2'b11, 5'd3}));
    @(negedge clk);
    acc_weight_req = 1'b1;
    wait_req(ok);
    chk("abort_fetch_seen", 32'(ok), 32'd1);
    acc_weight_req = 1'b0;
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    chk("abort_idle", 32'({busy, wfetch_req, acc_calc_start}), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'd1);
    chk("abort_no_err", 32'(err_cnt), 32'd2);

    // Fetch never acknowledged
    run = 1'b1; num_layers = 3'd1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    acc_weight_req = 1'b1;
    wait_req(ok);
    acc_weight_req = 1'b0;
    chk("stall_fetch_seen", 32'(ok), 32'd1);
`ifdef FC_SEQ_TIMEOUT_EN
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err) break;
      cnt++;
    end
    chk("tmo_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_err_idle", 32'({err, busy, wfetch_req}), 32'b100);
    @(negedge clk);
    #1;
    chk("tmo_err_count", 32'(err_cnt), 32'd3);
`else
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (wfetch_req && busy && !err) cnt++;
    end
    chk("no_tmo_waiting", 32'(cnt), 32'd1000);
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    @(negedge clk);
    #1;
    chk("no_tmo_err_count", 32'(err_cnt), 32'd2);
`endif

    // Asynchronous reset while in GRANT
    run = 1'b1; num_layers = 3'd1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    acc_weight_req = 1'b1;
    wait_req(ok);
    acc_weight_req = 1'b0;
    wfetch_ack = 1'b1;
    @(negedge clk);
    chk("pre_rst_grant", 32'(acc_calc_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 32'({busy, acc_weight_ack, acc_calc_start, wfetch_req, done, err}), 32'd0);
    chk("arst_cfg", acc_calc_len | acc_load_len | 32'(acc_load_sram_addr), 32'd0);
    chk("arst_flags", 32'({acc_do_bias, acc_do_quant, acc_quant_shift, acc_load_from_sram}),
        32'd0);
    chk("arst_bases", 32'({acc_fb_rd_base, acc_fb_wr_base}), 32'd0);
    wfetch_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1; num_layers = 3'd1;
    @(negedge clk);
    run = 1'b0;
    chk("post_rst_start", 32'(acc_start), 32'd1);
    chk("tbl_cleared", acc_calc_len | acc_load_len, 32'd0);
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    @(negedge clk);
    #1;
`ifdef FC_SEQ_TIMEOUT_EN
    chk("rst_no_done", 32'(done_cnt), 32'd1);
`else
    chk("rst_no_done", 32'(done_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
